// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-set key path.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } key_st_t;

  localparam int unsigned KEY_HU = 0;
  localparam int unsigned KEY_HD = 1;
  localparam int unsigned KEY_MU = 2;
  localparam int unsigned KEY_MD = 3;
  localparam int unsigned KEY_SU = 4;
  localparam int unsigned KEY_SD = 5;

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop sync, counter debounce, press pulse FSM.
// Auto-repeat (HOLD -> REPEAT timing) is built only when KEY_REPEAT_EN is defined.
module key_channel
  import clock_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 200,
  parameter int unsigned HOLD_CYCLES   = 5000,
  parameter int unsigned REPEAT_CYCLES = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned DbW = $clog2(DB_CYCLES + 1);

  logic [1:0]     sync_q;
  logic           sync;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           pulse_q, pulse_d;
  logic           rise;
  key_st_t        state_q, state_d;

  assign sync = sync_q[1];

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync != level_q) begin
      if (db_cnt_q == DbW'(DB_CYCLES - 1)) begin
        level_d = sync;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  // FSM decisions use level_d so a press pulse coincides with the level rise
  // and a release wins over a terminal count on the same edge.
  assign rise = level_d & ~level_q;

`ifdef KEY_REPEAT_EN
  localparam int unsigned TMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = $clog2(TMax + 1);

  logic [TW-1:0] t_cnt_q, t_cnt_d;
  logic          hold_done, rep_done;

  assign hold_done = (t_cnt_q == TW'(HOLD_CYCLES - 1));
  assign rep_done  = (t_cnt_q == TW'(REPEAT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    t_cnt_d = t_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HOLD;
          t_cnt_d = '0;
        end
      end
      HOLD: begin
        if (!level_d) begin
          state_d = IDLE;
          t_cnt_d = '0;
        end else if (hold_done) begin
          state_d = REPEAT;
          t_cnt_d = '0;
        end else begin
          t_cnt_d = t_cnt_q + TW'(1);
        end
      end
      REPEAT: begin
        if (!level_d) begin
          state_d = IDLE;
          t_cnt_d = '0;
        end else if (rep_done) begin
          t_cnt_d = '0;
        end else begin
          t_cnt_d = t_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        t_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE:    pulse_d = rise;
      HOLD:    pulse_d = level_d & hold_done;
      REPEAT:  pulse_d = level_d & rep_done;
      default: pulse_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_cnt_q <= '0;
    end else begin
      t_cnt_q <= t_cnt_d;
    end
  end
`else
  // Timing parameters are accepted but have no effect without auto-repeat.
  logic unused_params;
  assign unused_params = ^{HOLD_CYCLES, REPEAT_CYCLES};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = HOLD;
      HOLD:    if (!level_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE:    pulse_d = rise;
      default: pulse_d = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_raw};
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the six time-set buttons: one key_channel per key plus KEY_ANY.
// Auto-repeat is enabled by defining KEY_REPEAT_EN.
module key_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned N_KEYS        = 6,
  parameter int unsigned DB_CYCLES     = 200,
  parameter int unsigned HOLD_CYCLES   = 5000,
  parameter int unsigned REPEAT_CYCLES = 2000
) (
  input  logic              CP,
  input  logic              CR,
  input  logic [N_KEYS-1:0] KEY_IN,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] KEY_PULSE,
  output logic              KEY_ANY
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_channel (
      .clk    (CP),
      .rst_n  (CR),
      .key_raw(KEY_IN[i]),
      .level  (KEY_LEVEL[i]),
      .pulse  (KEY_PULSE[i])
    );
  end

  assign KEY_ANY = |KEY_LEVEL;

endmodule
